// File: rtl/call_scheduler_pkg.sv
// call_scheduler_pkg: floor codes, state encoding and floor-mask helpers for the call scheduler
package call_scheduler_pkg;
  localparam logic [1:0] FLOOR_NONE = 2'd0;
  localparam logic [1:0] F1 = 2'd1;
  localparam logic [1:0] F2 = 2'd2;
  localparam logic [1:0] F3 = 2'd3;
  localparam int DWELL_DEFAULT = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, SERVING = 2'd3} state_t;
  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    return f == F1 ? 3'b001 : f == F2 ? 3'b010 : f == F3 ? 3'b100 : 3'b000;
  endfunction
  function automatic logic [2:0] above_mask(input logic [1:0] f);
    return f == F1 ? 3'b110 : f == F2 ? 3'b100 : 3'b000;
  endfunction
  function automatic logic [2:0] below_mask(input logic [1:0] f);
    return f == F2 ? 3'b001 : f == F3 ? 3'b011 : 3'b000;
  endfunction
  function automatic logic [1:0] lowest_floor(input logic [2:0] m);
    return m[0] ? F1 : m[1] ? F2 : m[2] ? F3 : FLOOR_NONE;
  endfunction
  function automatic logic [1:0] highest_floor(input logic [2:0] m);
    return m[2] ? F3 : m[1] ? F2 : m[0] ? F1 : FLOOR_NONE;
  endfunction
endpackage

// File: rtl/call_edge.sv
// call_edge: registered rising-edge detector for the three call buttons, blind to buttons held through reset
module call_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] call_in,
  output logic [2:0] rise
);
  logic [2:0] prev, armed;
  always_ff @(posedge clk) begin
    prev  <= reset ? 3'b000 : call_in;
    armed <= reset ? ~call_in : armed | ~call_in;
  end
  assign rise = call_in & ~prev & armed;
endmodule

// File: rtl/call_scheduler.sv
// call_scheduler: latches floor calls and picks travel direction, target floor and door dwell
module call_scheduler
  import call_scheduler_pkg::*;
#(
  parameter int DWELL_TICKS = DWELL_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] call_in,
  input  logic [1:0] cur_floor,
  input  logic       alarm,
  output logic [2:0] pending,
  output logic [1:0] target_floor,
  output logic       target_valid,
  output logic       dir_up,
  output logic       dir_down,
  output logic       door_cmd
);
  state_t st, st_nx;
  logic last_up, last_up_nx, go, valid, here, reload;
  logic [2:0] rise, here_m, up_m, dn_m, clr, dwell, dwell_nx;
  logic [1:0] target_nx;
  call_edge u_edge (.clk(clk), .reset(reset), .call_in(call_in), .rise(rise));
  always_comb begin
    here_m = floor_bit(cur_floor);
    up_m = above_mask(cur_floor) & pending;
    dn_m = below_mask(cur_floor) & pending;
    valid = cur_floor != FLOOR_NONE;
    here = |(here_m & pending);
    go = tick & ~alarm;
    reload = st == SERVING && !alarm && valid && |(here_m & rise);
    st_nx = st;
    dwell_nx = dwell;
    last_up_nx = last_up;
    if (go) begin
      if (!valid) st_nx = IDLE;
      else if (st == SERVING) begin
        if (dwell > 3'd1) dwell_nx = dwell - 3'd1;
        else begin
          dwell_nx = 3'd0;
          if (last_up) st_nx = |up_m ? UP : |dn_m ? DOWN : IDLE;
          else st_nx = |dn_m ? DOWN : |up_m ? UP : IDLE;
        end
      end
      else if (here) st_nx = SERVING;
      else if (st == IDLE) st_nx = |up_m ? UP : |dn_m ? DOWN : IDLE;
      else if (st == UP) st_nx = |up_m ? UP : IDLE;
      else st_nx = |dn_m ? DOWN : IDLE;
    end
    if (reload) st_nx = SERVING;
    if (st_nx == SERVING && (st != SERVING || reload)) dwell_nx = 3'(DWELL_TICKS);
    clr = (st_nx == SERVING && (st != SERVING || reload)) ? here_m : 3'b000;
    last_up_nx = st_nx == UP ? 1'b1 : st_nx == DOWN ? 1'b0 : last_up;
    target_nx = !go ? target_floor : st_nx == UP ? lowest_floor(up_m) :
                st_nx == DOWN ? highest_floor(dn_m) : st_nx == SERVING ? cur_floor : FLOOR_NONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      last_up <= 1'b1;
      dwell <= 3'd0;
      target_floor <= FLOOR_NONE;
      pending <= 3'b000;
    end else begin
      st <= st_nx;
      last_up <= last_up_nx;
      dwell <= dwell_nx;
      target_floor <= target_nx;
      pending <= (pending | rise) & ~clr;
    end
  end
  assign target_valid = target_floor != FLOOR_NONE;
  assign dir_up = st == UP && !alarm;
  assign dir_down = st == DOWN && !alarm;
  assign door_cmd = st == SERVING || (alarm && !reset);
endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed scenarios with hand-computed expectations for call_scheduler
module tb_call_scheduler;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, alarm = 1'b0;
  logic [2:0] call_in = 3'b000;
  logic [1:0] cur_floor = 2'd1;
  logic [2:0] pending;
  logic [1:0] target_floor;
  logic target_valid, dir_up, dir_down, door_cmd;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  call_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .call_in(call_in), .cur_floor(cur_floor),
    .alarm(alarm), .pending(pending), .target_floor(target_floor),
    .target_valid(target_valid), .dir_up(dir_up), .dir_down(dir_down), .door_cmd(door_cmd)
  );
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (pending,target,valid,up,down,door)", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] obs();
    return {pending, target_floor, target_valid, dir_up, dir_down, door_cmd};
  endfunction
  function automatic logic [8:0] ex(input logic [2:0] p, input logic [1:0] t, input logic u, input logic d, input logic o);
    return {p, t, t != 2'd0, u, d, o};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask
  task automatic press(input logic [2:0] b);
    call_in = b;
    cyc();
    call_in = 3'b000;
    cyc();
  endtask
  initial begin
    cyc();
    cyc();
    check("reset", obs(), ex(3'b000, 2'd0, 0, 0, 0));
    reset = 1'b0;
    cyc();
    press(3'b100);
    check("latch_f3", obs(), ex(3'b100, 2'd0, 0, 0, 0));
    tk();
    check("up_to_f3", obs(), ex(3'b100, 2'd3, 1, 0, 0));
    press(3'b001);
    cur_floor = 2'd2;
    tk();
    check("up_f2_tgt3", obs(), ex(3'b101, 2'd3, 1, 0, 0));
    cur_floor = 2'd3;
    tk();
    check("serve_f3", obs(), ex(3'b001, 2'd3, 0, 0, 1));
    tk();
    tk();
    check("dwell_f3", obs(), ex(3'b001, 2'd3, 0, 0, 1));
    tk();
    check("down_to_f1", obs(), ex(3'b001, 2'd1, 0, 1, 0));
    cur_floor = 2'd2;
    tk();
    check("down_f2", obs(), ex(3'b001, 2'd1, 0, 1, 0));
    cur_floor = 2'd1;
    tk();
    check("serve_f1", obs(), ex(3'b000, 2'd1, 0, 0, 1));
    tk();
    tk();
    tk();
    check("idle_after", obs(), ex(3'b000, 2'd0, 0, 0, 0));
    press(3'b010);
    tk();
    check("up_to_f2", obs(), ex(3'b010, 2'd2, 1, 0, 0));
    alarm = 1'b1;
    cyc();
    check("alarm_hold", obs(), ex(3'b010, 2'd2, 0, 0, 1));
    press(3'b001);
    tk();
    check("alarm_latch", obs(), ex(3'b011, 2'd2, 0, 0, 1));
    alarm = 1'b0;
    cyc();
    check("alarm_release", obs(), ex(3'b011, 2'd2, 1, 0, 0));
    cur_floor = 2'd2;
    tk();
    check("serve_f2", obs(), ex(3'b001, 2'd2, 0, 0, 1));
    tk();
    tk();
    press(3'b010);
    check("reload_clear", obs(), ex(3'b001, 2'd2, 0, 0, 1));
    tk();
    check("reload_dwell2", obs(), ex(3'b001, 2'd2, 0, 0, 1));
    tk();
    check("reload_dwell1", obs(), ex(3'b001, 2'd2, 0, 0, 1));
    tk();
    check("down_from_f2", obs(), ex(3'b001, 2'd1, 0, 1, 0));
    press(3'b010);
    check("pending_011", obs(), ex(3'b011, 2'd1, 0, 1, 0));
    call_in = 3'b100;
    reset = 1'b1;
    cyc();
    check("reset_mid_down", obs(), ex(3'b000, 2'd0, 0, 0, 0));
    reset = 1'b0;
    cyc();
    cyc();
    check("held_ignored", obs(), ex(3'b000, 2'd0, 0, 0, 0));
    call_in = 3'b000;
    cyc();
    press(3'b100);
    check("repress", obs(), ex(3'b100, 2'd0, 0, 0, 0));
    cur_floor = 2'd0;
    tk();
    check("invalid_idle", obs(), ex(3'b100, 2'd0, 0, 0, 0));
    cur_floor = 2'd1;
    tk();
    check("up_again", obs(), ex(3'b100, 2'd3, 1, 0, 0));
    cur_floor = 2'd0;
    tk();
    check("invalid_abort", obs(), ex(3'b100, 2'd0, 0, 0, 0));
    cur_floor = 2'd3;
    press(3'b001);
    tk();
    check("serve_f3_top", obs(), ex(3'b001, 2'd3, 0, 0, 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 Parameter DWELL_TICKS, default 3, is the number of tick pulses the door is held open at a served floor (range 1..7).
REQ-002 Port clk, input, 1: single system clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port tick, input, 1: one-clk-wide enable pulse from the clock divisor (1 Hz); it paces all state transitions.
REQ-005 Port call_in, input, 3: debounced floor-call buttons, active-high, bit i = floor i+1.
REQ-006 Port cur_floor, input, 2: current floor from the floor FSM; 1..3 are valid, 0 is invalid.
REQ-007 Port alarm, input, 1: overload alarm from the load counter; when high it freezes scheduling.
REQ-008 Port pending, output, 3: latched, unserved calls, bit i = floor i+1.
REQ-009 Port target_floor, output, 2: floor currently being headed to; 0 means no target.
REQ-010 Port target_valid, output, 1: high when target_floor is nonzero.
REQ-011 Port dir_up and port dir_down, outputs, 1 each: travel direction; they are never both high; both low means stopped.
REQ-012 Port door_cmd, output, 1: door-open request to the floor FSM, high throughout SERVING.

Function
REQ-013 Each call_in bit SHALL be edge-detected against a registered copy; a rising edge sets the matching pending bit on the next clk, independent of tick and alarm.
REQ-014 The FSM SHALL have four states: IDLE, UP, DOWN, SERVING; it SHALL evaluate transitions only on cycles where tick=1 and alarm=0.
REQ-015 IDLE transitions: pending bit at cur_floor set -> SERVING; otherwise any pending above -> UP; otherwise any pending below -> DOWN; otherwise stay in IDLE.
REQ-016 UP/DOWN transition: pending bit at cur_floor set -> SERVING, and last_dir records the direction.
REQ-017 On entry to SERVING, the FSM SHALL clear the pending bit for cur_floor and load the dwell counter with DWELL_TICKS.
REQ-018 SERVING behaviour: dwell decrements per tick; at 0 the FSM continues in last_dir if pending exists that way, else reverses if pending exists the other way, else goes to IDLE.
REQ-019 target_floor SHALL follow this rule: in UP, the lowest pending floor above cur_floor; in DOWN, the highest pending floor below cur_floor; in SERVING, cur_floor; in IDLE, 0. It is registered and updates on the same clk as the state.
REQ-020 Direction outputs: dir_up=1 only in UP; dir_down=1 only in DOWN; door_cmd=1 only in SERVING.
REQ-021 Simultaneous events: a call edge for cur_floor arriving during SERVING SHALL keep the bit clear and reload dwell to DWELL_TICKS; clear wins over set.
REQ-022 Alarm: while alarm=1, state, dwell and target SHALL hold; dir_up=dir_down=0; door_cmd=1; call latching continues.
REQ-023 Invalid floor: when cur_floor=0, the FSM SHALL stay in or return to IDLE on tick and SHALL NOT clear any pending bit.
REQ-024 Boundaries: no UP from floor 3 and no DOWN from floor 1; an UP with no pending above at a tick SHALL go to IDLE.

Reset
REQ-025 When reset=1 on a clk edge, the following SHALL take effect on that edge, overriding tick, alarm and calls: pending=000, state=IDLE, last_dir=up, dwell=0, target_floor=0, target_valid=0, dir_up=dir_down=door_cmd=0, edge registers=0.
REQ-026 Reset asserted mid-SERVING or mid-travel SHALL discard all pending calls; a call held high through reset release SHALL NOT register until it falls and rises again.

Structure
REQ-027 A shared package SHALL hold the floor codes (FLOOR_NONE=0, F1=1, F2=2, F3=3), the 2-bit state encoding, and the DWELL_TICKS default.
REQ-028 One sub-module, call_edge, SHALL implement the 3-bit registered rising-edge detector; everything else is in call_scheduler.

Verification
REQ-029 Scenario: reset, then cur_floor=1 and call_in pulse bit 2 -> pending=100 next clk; next tick gives UP with target_floor=3, dir_up=1.
REQ-030 Scenario: cur_floor steps to 3 while in UP -> next tick gives SERVING, pending=000, door_cmd=1 for 3 ticks, then IDLE.
REQ-031 Scenario: at floor 2 in UP with pending=101 -> UP targets 3; after serving floor 3, DOWN targets 1.
REQ-032 Scenario: alarm=1 during UP, with a call pulse on floor 1 -> dir_up=0, door_cmd=1, state held, pending bit 0 set; on alarm release UP resumes.
REQ-033 Scenario: during SERVING at floor 2 with dwell=1, a call_in bit 1 pulse -> pending stays 000 and dwell reloads to 3.
REQ-034 Scenario: reset asserted mid-DOWN with pending=011 -> all outputs zero on the next clk; a call held high through reset is ignored until re-pressed.
